// File: rtl/calc_pkg.sv
// Shared encodings for the 2-bit calculator key sequencer and its ALU.
package calc_pkg;

  localparam int unsigned KEY_W   = 2;
  localparam int unsigned OPND_W  = 2;
  localparam int unsigned RES_W   = 4;
  localparam int unsigned STATE_W = 3;

  localparam logic [KEY_W-1:0] KEY_DIGIT = 2'b00;
  localparam logic [KEY_W-1:0] KEY_OP    = 2'b01;
  localparam logic [KEY_W-1:0] KEY_EQ    = 2'b10;
  localparam logic [KEY_W-1:0] KEY_CLR   = 2'b11;

  localparam logic [OPND_W-1:0] OP_ADD  = 2'b00;
  localparam logic [OPND_W-1:0] OP_SUB  = 2'b01;
  localparam logic [OPND_W-1:0] OP_MUL  = 2'b10;
  localparam logic [OPND_W-1:0] OP_RSVD = 2'b11;

  localparam logic [STATE_W-1:0] ST_A    = 3'd0;
  localparam logic [STATE_W-1:0] ST_OP   = 3'd1;
  localparam logic [STATE_W-1:0] ST_B    = 3'd2;
  localparam logic [STATE_W-1:0] ST_EQ   = 3'd3;
  localparam logic [STATE_W-1:0] ST_EXEC = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    S_A    = ST_A,
    S_OP   = ST_OP,
    S_B    = ST_B,
    S_EQ   = ST_EQ,
    S_EXEC = ST_EXEC,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/alu_2bit.sv
// Combinational 2-bit ALU: add, sign-extended subtract, multiply with a status bit.
module alu_2bit
  import calc_pkg::*;
(
  input  logic [OPND_W-1:0] a_i,
  input  logic [OPND_W-1:0] b_i,
  input  logic [OPND_W-1:0] op_i,
  output logic [RES_W-1:0]  result_o,
  output logic              status_o
);

  logic [RES_W:0]   sum;
  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;

  assign a_ext = RES_W'(a_i);
  assign b_ext = RES_W'(b_i);
  assign sum   = (RES_W+1)'(a_ext) + (RES_W+1)'(b_ext);

  always_comb begin
    result_o = '0;
    status_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = sum[RES_W-1:0];
        status_o = sum[RES_W];
      end
      // Two's-complement wrap of the 4-bit difference gives the sign extension.
      OP_SUB: begin
        result_o = a_ext - b_ext;
        status_o = (b_i > a_i);
      end
      OP_MUL: begin
        result_o = a_ext * b_ext;
        status_o = result_o[RES_W-1];
      end
      default: begin
        result_o = '0;
        status_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/calc_sequencer.sv
// Key-entry sequencer: assembles A, op, B from key events and runs one ALU op on equals.
module calc_sequencer
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [KEY_W-1:0]  key_kind,
  input  logic [KEY_W-1:0]  key_val,
  output logic [OPND_W-1:0] opnd_a,
  output logic [OPND_W-1:0] opnd_b,
  output logic [OPND_W-1:0] opnd_op,
  output logic [RES_W-1:0]  result,
  output logic              status,
  output logic              result_valid,
  output logic              err
);

  state_e            state_q;
  logic [OPND_W-1:0] a_q;
  logic [OPND_W-1:0] b_q;
  logic [OPND_W-1:0] op_q;
  logic [RES_W-1:0]  result_q;
  logic              status_q;
  logic              valid_q;
  logic              err_q;
  logic [RES_W-1:0]  alu_result;
  logic              alu_status;
  logic              key_acc;

  alu_2bit u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_result),
    .status_o (alu_status)
  );

  assign key_ready = (state_q != S_EXEC);
  assign key_acc   = key_valid && key_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      status_q <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else if (state_q == S_EXEC) begin
      result_q <= alu_result;
      status_q <= alu_status;
      valid_q  <= 1'b1;
      state_q  <= S_DONE;
    end else if (key_acc) begin
      if (key_kind == KEY_CLR) begin
        state_q  <= S_A;
        a_q      <= '0;
        b_q      <= '0;
        op_q     <= '0;
        result_q <= '0;
        status_q <= 1'b0;
        valid_q  <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        case (state_q)
          S_A: begin
            if (key_kind == KEY_DIGIT) begin
              a_q     <= key_val;
              state_q <= S_OP;
            end else begin
              err_q <= 1'b1;
            end
          end
          S_OP, S_B: begin
            if (key_kind == KEY_DIGIT) begin
              if (state_q == S_OP) begin
                a_q <= key_val;
              end else begin
                b_q     <= key_val;
                state_q <= S_EQ;
              end
            end else if (key_kind == KEY_OP && key_val != OP_RSVD) begin
              op_q    <= key_val;
              state_q <= S_B;
            end else begin
              err_q <= 1'b1;
            end
          end
          S_EQ: begin
            if (key_kind == KEY_DIGIT) begin
              b_q <= key_val;
            end else if (key_kind == KEY_EQ) begin
              state_q <= S_EXEC;
            end else begin
              err_q <= 1'b1;
            end
          end
          // A new digit starts the next calculation; B and op carry over.
          S_DONE: begin
            if (key_kind == KEY_DIGIT) begin
              a_q      <= key_val;
              result_q <= '0;
              status_q <= 1'b0;
              valid_q  <= 1'b0;
              state_q  <= S_OP;
            end else if (key_kind == KEY_EQ) begin
              state_q <= S_EXEC;
            end else begin
              err_q <= 1'b1;
            end
          end
          default: state_q <= S_A;
        endcase
      end
    end
  end

  assign opnd_a       = a_q;
  assign opnd_b       = b_q;
  assign opnd_op      = op_q;
  assign result       = result_q;
  assign status       = status_q;
  assign result_valid = valid_q;
  assign err          = err_q;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Key-entry sequencer for the 2-bit calculator datapath. Accepts one key event per handshake (digit, operator, equals, clear) and assembles operand A, operator and operand B. On equals it runs one `alu_2bit` operation, then holds the registered result and status for the display path. Sits between the keypad decoder and the result/display logic, and owns the only `alu_2bit` instance.

## Interface
Parameters: none.

Ports:
- `clk` — in, 1: system clock, rising-edge.
- `rst` — in, 1: reset, asynchronous, active-high.
- `key_valid` — in, 1: key event present.
- `key_ready` — out, 1: sequencer can accept a key this cycle.
- `key_kind` — in, 2: 00 = digit, 01 = operator, 10 = equals, 11 = clear.
- `key_val` — in, 2: digit value (0–3) or operator code (00 = add, 01 = sub, 10 = mul).
- `opnd_a` — out, 2: registered operand A.
- `opnd_b` — out, 2: registered operand B.
- `opnd_op` — out, 2: registered operator.
- `result` — out, 4: registered ALU result.
- `status` — out, 1: registered ALU status (carry / borrow / overflow).
- `result_valid` — out, 1: `result`/`status` hold a completed operation.
- `err` — out, 1: sticky entry error.

## Operation
- A key is accepted on a rising edge with `key_valid && key_ready`. Unaccepted keys have no effect.
- `key_ready` = 1 in every state except EXEC; it is a combinational decode of state.

State machine:
- **S_A** (reset state)
  - Digit → A = `key_val`, go to S_OP.
  - Operator or equals → set `err`, stay.
- **S_OP**
  - Digit → replace A.
  - Operator 00/01/10 → latch op, go to S_B.
  - Operator 11 → set `err`, stay.
  - Equals → set `err`, stay.
- **S_B**
  - Digit → B = `key_val`, go to S_EQ.
  - Operator 00/01/10 → replace op.
  - Operator 11 → set `err`, stay.
  - Equals → set `err`, stay.
- **S_EQ**
  - Digit → replace B.
  - Operator → set `err`, stay.
  - Equals → go to EXEC.
- **EXEC** (exactly one cycle)
  - ALU is driven combinationally from `opnd_a`/`opnd_b`/`opnd_op`.
  - On exit: `result` ← ALU result, `status` ← ALU status, `result_valid` ← 1, go to S_DONE.
- **S_DONE**
  - Digit → A = `key_val`; `result`, `status`, `result_valid` cleared to 0; B and op retained; go to S_OP.
  - Equals → go to EXEC (re-executes the same operands).
  - Operator → set `err`, stay.

Clear key:
- Accepted in any state except EXEC.
- Zeroes A, B, op, `result`, `status`, `result_valid` and `err`; go to S_A.

Error flag:
- `err` is cleared only by clear or `rst`.
- `err` never blocks further entry.

Arithmetic (defined by `alu_2bit`, not re-implemented here):
- Sub: sign-extended 4-bit difference; status = 1 when B > A.
- Mul: status = `result[3]`.

## Timing
- Reset values:
  - State = S_A, `key_ready` = 1.
  - `opnd_a`, `opnd_b`, `opnd_op` = 0.
  - `result` = 0, `status` = 0, `result_valid` = 0, `err` = 0.
- Operand and `err` updates are visible the cycle after key acceptance.
- Equals accepted at edge N:
  - EXEC during cycle N..N+1, `key_ready` = 0.
  - `result`, `status` and `result_valid` valid after edge N+1. Latency is 1 cycle.
- `key_valid` held through EXEC: the key is not consumed and is accepted on the first edge after EXEC, in S_DONE.
- `result_valid` stays 1 through S_DONE until a digit or clear is accepted.
- `rst` mid-EXEC: immediate asynchronous return to reset values; no result is latched.
- Back-to-back keys, one per cycle, are legal in every non-EXEC state.

## Structure
- Package `calc_pkg`:
  - key-kind encodings: `KEY_DIGIT`, `KEY_OP`, `KEY_EQ`, `KEY_CLR`;
  - ALU op encodings: `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_RSVD`;
  - 3-bit state encoding constants.
- Single sub-module: one `alu_2bit` instance fed from the operand registers.
- Everything else (state register, operand, result and error registers) is flat in `calc_sequencer`.

## Test plan
- **Add:** digit 3, op 00, digit 2, equals → `result` = 0101, `status` = 0, `result_valid` rises one cycle after equals acceptance.
- **Sub borrow:** digit 1, op 01, digit 3, equals → `result` = 1110, `status` = 1; then equals again → same values after a new EXEC cycle with `key_ready` low for one cycle.
- **Mul and replacement:** digit 2, digit 3 (A becomes 3), op 00, op 10 (op becomes mul), digit 3, equals → `result` = 1001, `status` = 1.
- **Errors:** equals in S_A → `err` = 1, state S_A. Then digit 1, op 11 → `err` stays 1, state S_B is not entered. Then clear → `err` = 0, all outputs 0.
- **Handshake:** `key_valid` held with digit 2 across EXEC → not accepted while `key_ready` = 0; accepted next edge, `opnd_a` = 2, `result_valid` → 0.
- **Reset mid-operation:** assert `rst` during EXEC → all outputs 0 immediately, `result_valid` never rises; after release, digit 1 accepted as A.
